// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_pkg                                                    |
// | Brief  : shared types and register map for the UART TX peripheral    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_COUNT   = 8;
  localparam int CTRL_CLR_OVF = 3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_periph_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_tx_periph_if                                           |
// | Brief  : core data-bus port of the UART TX peripheral                |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface uart_tx_periph_if;

  logic        we_i;
  logic        re_i;
  logic        addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output we_i,
    output re_i,
    output addr_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  we_i,
    input  re_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_periph_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sync_fifo                                                   |
// | Brief  : first-word fall-through FIFO, push accepted when full+pop    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic                     i_pop,
  input  wire logic [WIDTH-1:0]         i_data,
  output logic      [WIDTH-1:0]         o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_tx_periph                                              |
// | Brief  : memory-mapped 8N1 UART transmitter with TX FIFO and status  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  wire logic        clk_100m_i,
  input  wire logic        rst_i,
  uart_tx_periph_if.slave  bus,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_periph: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_tx_periph: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_ovf;
  logic [31:0] r_rdata;
  logic [31:0] w_status;
  logic        w_pop;
  logic        w_push;
  logic        w_baud_end;
  logic [7:0]  w_fifo_data;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_unused_wdata;

  assign w_push         = bus.we_i && (bus.addr_i == ADDR_DATA);
  assign w_ovf_set      = w_push && w_full && !w_pop;
  assign w_ovf_clr      = bus.we_i && (bus.addr_i == ADDR_STATUS) && bus.wdata_i[CTRL_CLR_OVF];
  assign w_unused_wdata = ^bus.wdata_i[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_100m_i),
    .rst     (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.wdata_i[7:0]),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign busy_o      = (r_state != TX_IDLE) || !w_empty;
  assign tx_o        = r_tx;
  assign bus.rdata_o = r_rdata;

  always_comb begin
    w_status                     = '0;
    w_status[STAT_BUSY]          = busy_o;
    w_status[STAT_EMPTY]         = w_empty;
    w_status[STAT_FULL]          = w_full;
    w_status[STAT_OVF]           = r_ovf;
    w_status[STAT_COUNT +: AW+1] = w_count;
  end

  assign w_baud_end = (r_baud == CW'(DIV - 1));

  // Line level is registered from the current state, so tx_o lags the FSM by one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = TX_DATA;
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      TX_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = TX_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      TX_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_bit_nxt   = '0;
            w_state_nxt = TX_START;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m_i) begin
    if (rst_i) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (bus.re_i) begin
        r_rdata <= (bus.addr_i == ADDR_STATUS) ? w_status : 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_uart_tx_periph                                           |
// | Brief  : directed self-checking bench, DIV=10, FIFO_DEPTH=4          |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_uart_tx_periph;

  logic clk;
  logic rst;
  logic tx;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_periph_if bus_if ();

  uart_tx_periph #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_100m_i (clk),
    .rst_i      (rst),
    .bus        (bus_if),
    .tx_o       (tx),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected line level j cycles after tx first drops, for n back-to-back frames
  function automatic logic exp_line(input logic [39:0] msg, input int n, input int j);
    int f;
    int b;
    if (j < 0 || j >= 100 * n) return 1'b1;
    f = j / 100;
    b = (j % 100) / 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return msg[f * 8 + b - 1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    bus_if.we_i    = 1'b1;
    bus_if.addr_i  = a;
    bus_if.wdata_i = d;
    tick();
    bus_if.we_i    = 1'b0;
    bus_if.wdata_i = '0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    bus_if.re_i   = 1'b1;
    bus_if.addr_i = a;
    tick();
    bus_if.re_i   = 1'b0;
    d = bus_if.rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus_if.rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: tx=%b busy=%b rdata=%h, want 1 0 00000000", tx, busy, bus_if.rdata_o);
    end
    bus_read(1'b1, rd);
    n_tests++;
    if (rd !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL reset_status: got %h want 00000002", rd);
    end
    repeat (3) tick();
    n_tests++;
    if (bus_if.rdata_o !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h want 00000002", bus_if.rdata_o);
    end
  endtask

  task automatic test_single_frame();
    logic [39:0] msg;
    do_reset();
    msg = {32'h0, 8'h48};
    bus_write(1'b0, 32'h0000_0048);
    for (int k = 0; k <= 105; k++) begin
      n_tests++;
      if (tx !== exp_line(msg, 1, k - 2)) begin
        n_fail++;
        $display("FAIL single_tx k=%0d: got %b want %b", k, tx, exp_line(msg, 1, k - 2));
      end
      if (k == 100 || k == 101) begin
        n_tests++;
        if (busy !== (k == 100)) begin
          n_fail++;
          $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k == 100));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] msg;
    do_reset();
    msg = {8'h00, 8'h41, 8'h4C, 8'h4F, 8'h48};
    bus_write(1'b0, 32'h48);
    bus_write(1'b0, 32'h4F);
    bus_write(1'b0, 32'h4C);
    bus_write(1'b0, 32'h41);
    for (int k = 3; k <= 405; k++) begin
      n_tests++;
      if (tx !== exp_line(msg, 4, k - 2)) begin
        n_fail++;
        $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx, exp_line(msg, 4, k - 2));
      end
      if (k == 400 || k == 401) begin
        n_tests++;
        if (busy !== (k == 400)) begin
          n_fail++;
          $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, (k == 400));
        end
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [39:0] msg;
    logic [31:0] rd;
    do_reset();
    msg = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    bus_write(1'b0, 32'h11);
    bus_write(1'b0, 32'h22);
    bus_write(1'b0, 32'h33);
    bus_write(1'b0, 32'h44);
    bus_write(1'b0, 32'h55);
    bus_write(1'b0, 32'h66);
    bus_read(1'b1, rd);
    n_tests++;
    if (rd !== 32'h0000_040D) begin
      n_fail++;
      $display("FAIL ovf_status: got %h want 0000040d", rd);
    end
    bus_write(1'b1, 32'h0000_0008);
    bus_read(1'b1, rd);
    n_tests++;
    if (rd !== 32'h0000_0405) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h want 00000405", rd);
    end
    for (int k = 8; k <= 505; k++) begin
      n_tests++;
      if (tx !== exp_line(msg, 5, k - 2)) begin
        n_fail++;
        $display("FAIL ovf_tx k=%0d: got %b want %b", k, tx, exp_line(msg, 5, k - 2));
      end
      if (k == 500 || k == 501) begin
        n_tests++;
        if (busy !== (k == 500)) begin
          n_fail++;
          $display("FAIL ovf_busy k=%0d: got %b want %b", k, busy, (k == 500));
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [31:0] rd;
    do_reset();
    bus_write(1'b0, 32'hA5);
    bus_write(1'b0, 32'h5A);
    bus_write(1'b0, 32'h3C);
    repeat (42) tick();
    n_tests++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bit3: got %b want 0", tx);
    end
    do_reset();
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus_if.rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: tx=%b busy=%b rdata=%h, want 1 0 00000000", tx, busy, bus_if.rdata_o);
    end
    bus_read(1'b1, rd);
    n_tests++;
    if (rd !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL midrst_status: got %h want 00000002", rd);
    end
    for (int k = 0; k < 150; k++) begin
      n_tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet k=%0d: tx=%b busy=%b, want 1 0", k, tx, busy);
      end
      tick();
    end
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] rd;
    do_reset();
    bus_read(1'b1, rd);
    bus_read(1'b0, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL data_read: got %h want 00000000", rd);
    end
    for (int i = 0; i < 6; i++) bus_write(1'b0, 32'h30 + i);
    bus_if.we_i    = 1'b1;
    bus_if.re_i    = 1'b1;
    bus_if.addr_i  = 1'b1;
    bus_if.wdata_i = 32'h0000_0008;
    tick();
    bus_if.we_i    = 1'b0;
    bus_if.re_i    = 1'b0;
    bus_if.wdata_i = '0;
    n_tests++;
    if (bus_if.rdata_o !== 32'h0000_040D) begin
      n_fail++;
      $display("FAIL rw_pre_state: got %h want 0000040d", bus_if.rdata_o);
    end
    bus_read(1'b1, rd);
    n_tests++;
    if (rd !== 32'h0000_0405) begin
      n_fail++;
      $display("FAIL rw_after_clear: got %h want 00000405", rd);
    end
    do_reset();
  endtask

  initial begin
    rst            = 1'b1;
    bus_if.we_i    = 1'b0;
    bus_if.re_i    = 1'b0;
    bus_if.addr_i  = 1'b0;
    bus_if.wdata_i = '0;
    repeat (2) tick();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_mid_frame_reset();
    test_read_write_same_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
